mem_port_arbiter: RTL

Arbitrates the core's two memory clients, instruction fetch and load/store, onto one single-ported DRAM request/response interface. It allows one outstanding transaction at a time. Load/store has priority, with a bounded-starvation rule for fetch. The block sits between the pipeline's fetch/memory stages and main memory. Each response is routed back to the client that issued it.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the width of the data-streak counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } mem_owner_e;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection: load/store wins unless fetch has waited through
// MAX_DATA_STREAK consecutive data grants.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                instr_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output mem_owner_e          winner
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX_DATA_STREAK);

  always_comb begin
    winner = OWN_DATA;
    if (instr_req && (!data_req || streak == LIMIT)) begin
      winner = OWN_INSTR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-client (fetch, load/store) arbiter onto a single-outstanding DRAM port.
// All client and memory outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic                instr_gnt,
  output logic                instr_rvalid,
  output logic [DATA_W-1:0]   instr_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  mem_arb_state_e      state;
  mem_owner_e          owner;
  mem_owner_e          winner;
  logic [STREAK_W-1:0] streak;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .instr_req(instr_req),
    .data_req (data_req),
    .streak   (streak),
    .winner   (winner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= OWN_INSTR;
      streak       <= '0;
      instr_gnt    <= 1'b0;
      instr_rvalid <= 1'b0;
      instr_rdata  <= '0;
      data_gnt     <= 1'b0;
      data_rvalid  <= 1'b0;
      data_rdata   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      // Grants and responses are single-cycle pulses.
      instr_gnt    <= 1'b0;
      data_gnt     <= 1'b0;
      instr_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_req || data_req) begin
            state   <= REQ;
            owner   <= winner;
            mem_req <= 1'b1;
            if (winner == OWN_DATA) begin
              data_gnt  <= 1'b1;
              mem_we    <= data_we;
              mem_be    <= data_be;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              if (!instr_req) begin
                streak <= '0;
              end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
              end
            end else begin
              instr_gnt <= 1'b1;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_addr  <= instr_addr;
              mem_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner == OWN_DATA) begin
              data_rvalid <= 1'b1;
              data_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              instr_rvalid <= 1'b1;
              instr_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
